// File: rtl/reg_file_wb_sink.sv
// Register file sink of the write-back stage: 2 bypassed read ports plus a per-register
// in-flight write scoreboard. Debug ports are added when REGFILE_DEBUG_PORT_EN is defined.
module reg_file_wb_sink #(
   parameter int unsigned CNT_W = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        RegWrite,
   input  logic [4:0]  WriteRegAddr,
   input  logic [31:0] WriteRegData,
   input  logic [4:0]  ReadAddr1,
   input  logic [4:0]  ReadAddr2,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   input  logic        IssueValid,
   input  logic [4:0]  IssueAddr,
   output logic        Busy1,
   output logic        Busy2,
`ifdef REGFILE_DEBUG_PORT_EN
   input  logic [4:0]  DbgAddr,
   output logic [31:0] DbgData,
   output logic [31:0] WriteCount,
`endif
   output logic        ScoreErr
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [31:0]      regs_q [32];
   logic [31:0]      regs_d [32];
   logic [CNT_W-1:0] cnt_q  [32];
   logic [CNT_W-1:0] cnt_d  [32];
   logic             score_err_q, score_err_d;
   logic             wr_en, iss_en;

   always_comb begin
      wr_en       = RegWrite && (WriteRegAddr != 5'd0);
      iss_en      = IssueValid && (IssueAddr != 5'd0);
      regs_d      = regs_q;
      cnt_d       = cnt_q;
      score_err_d = score_err_q;
      if (wr_en) regs_d[WriteRegAddr] = WriteRegData;
      // Issue and release to one register in the same cycle cancel out.
      if (!(wr_en && iss_en && (WriteRegAddr == IssueAddr))) begin
         if (iss_en) begin
            if (cnt_q[IssueAddr] == CntMax) score_err_d = 1'b1;
            else cnt_d[IssueAddr] = cnt_q[IssueAddr] + CntOne;
         end
         if (wr_en) begin
            if (cnt_q[WriteRegAddr] == '0) score_err_d = 1'b1;
            else cnt_d[WriteRegAddr] = cnt_q[WriteRegAddr] - CntOne;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         score_err_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         cnt_q       <= cnt_d;
         score_err_q <= score_err_d;
      end
   end

   always_comb begin
      ReadData1 = regs_q[ReadAddr1];
      if (ReadAddr1 == 5'd0) ReadData1 = '0;
      else if (RegWrite && (WriteRegAddr == ReadAddr1)) ReadData1 = WriteRegData;
      ReadData2 = regs_q[ReadAddr2];
      if (ReadAddr2 == 5'd0) ReadData2 = '0;
      else if (RegWrite && (WriteRegAddr == ReadAddr2)) ReadData2 = WriteRegData;
      // The last outstanding write being bypassed right now no longer stalls the reader.
      Busy1 = (ReadAddr1 != 5'd0) && (cnt_q[ReadAddr1] != '0) &&
              !(RegWrite && (WriteRegAddr == ReadAddr1) && (cnt_q[ReadAddr1] == CntOne));
      Busy2 = (ReadAddr2 != 5'd0) && (cnt_q[ReadAddr2] != '0) &&
              !(RegWrite && (WriteRegAddr == ReadAddr2) && (cnt_q[ReadAddr2] == CntOne));
   end

   assign ScoreErr = score_err_q;

`ifdef REGFILE_DEBUG_PORT_EN
   logic [31:0] write_count_q, write_count_d;

   always_comb begin
      write_count_d = write_count_q;
      if (wr_en) write_count_d = write_count_q + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) write_count_q <= '0;
      else write_count_q <= write_count_d;
   end

   assign WriteCount = write_count_q;
   assign DbgData    = (DbgAddr == 5'd0) ? 32'd0 : regs_q[DbgAddr];
`endif

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Self-checking bench for reg_file_wb_sink: expectations are queued when stimulus is applied
// and popped against the DUT outputs once the combinational logic has settled.
module tb_reg_file_wb_sink;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        RegWrite;
   logic [4:0]  WriteRegAddr;
   logic [31:0] WriteRegData;
   logic [4:0]  ReadAddr1, ReadAddr2;
   logic [31:0] ReadData1, ReadData2;
   logic        IssueValid;
   logic [4:0]  IssueAddr;
   logic        Busy1, Busy2, ScoreErr;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [4:0]  DbgAddr;
   logic [31:0] DbgData, WriteCount;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   always #5 Clk = ~Clk;

   reg_file_wb_sink #(.CNT_W(2)) dut (
      .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteRegAddr(WriteRegAddr),
      .WriteRegData(WriteRegData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .IssueValid(IssueValid),
      .IssueAddr(IssueAddr), .Busy1(Busy1), .Busy2(Busy2),
`ifdef REGFILE_DEBUG_PORT_EN
      .DbgAddr(DbgAddr), .DbgData(DbgData), .WriteCount(WriteCount),
`endif
      .ScoreErr(ScoreErr)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0; WriteRegAddr = '0; WriteRegData = '0;
      IssueValid = 1'b0; IssueAddr = '0;
   endtask

   task automatic issue(input logic [4:0] a);
      IssueValid = 1'b1; IssueAddr = a;
      tick();
      idle();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      // Write and issue while Reset is high must be ignored.
      RegWrite = 1'b1; WriteRegAddr = 5'd6; WriteRegData = 32'h6666_6666;
      IssueValid = 1'b1; IssueAddr = 5'd6;
      do_reset();
      idle();
      for (int a = 0; a < 32; a++) begin
         ReadAddr1 = 5'(a); ReadAddr2 = 5'(31 - a);
         exp_q.push_back(32'd0); exp_q.push_back(32'd0);
         exp_q.push_back(32'd0); exp_q.push_back(32'd0);
         #1;
         e = exp_q.pop_front(); checks++;
         if (ReadData1 !== e) begin failures++; $display("FAIL reset_rd1 a=%0d got=%h want=%h", a, ReadData1, e); end
         e = exp_q.pop_front(); checks++;
         if (ReadData2 !== e) begin failures++; $display("FAIL reset_rd2 a=%0d got=%h want=%h", a, ReadData2, e); end
         e = exp_q.pop_front(); checks++;
         if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL reset_busy1 a=%0d got=%b want=%0d", a, Busy1, e); end
         e = exp_q.pop_front(); checks++;
         if ({31'd0, Busy2} !== e) begin failures++; $display("FAIL reset_busy2 a=%0d got=%b want=%0d", a, Busy2, e); end
      end
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL reset_err got=%b want=%0d", ScoreErr, e); end
   endtask

   task automatic test_write_read();
      logic [31:0] e;
      issue(5'd5);
      ReadAddr1 = 5'd5;
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL wr_busy_issued got=%b want=%0d", Busy1, e); end
      RegWrite = 1'b1; WriteRegAddr = 5'd5; WriteRegData = 32'hDEAD_BEEF;
      tick();
      idle();
      exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL wr_rd5 got=%h want=%h", ReadData1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL wr_busy5 got=%b want=%0d", Busy1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL wr_err got=%b want=%0d", ScoreErr, e); end
      RegWrite = 1'b1; WriteRegAddr = 5'd0; WriteRegData = 32'h0000_1234; ReadAddr1 = 5'd0;
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL wr0_bypass got=%h want=%h", ReadData1, e); end
      tick();
      idle();
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL wr0_rd got=%h want=%h", ReadData1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL wr0_err got=%b want=%0d", ScoreErr, e); end
   endtask

   task automatic test_bypass();
      logic [31:0] e;
      issue(5'd7);
      RegWrite = 1'b1; WriteRegAddr = 5'd7; WriteRegData = 32'hA5A5_A5A5;
      ReadAddr1 = 5'd5; ReadAddr2 = 5'd7;
      exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'd0); exp_q.push_back(32'hDEAD_BEEF);
      #1;
      e = exp_q.pop_front(); checks++;
      if (ReadData2 !== e) begin failures++; $display("FAIL byp_rd2 got=%h want=%h", ReadData2, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy2} !== e) begin failures++; $display("FAIL byp_busy2 got=%b want=%0d", Busy2, e); end
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL byp_rd1_other got=%h want=%h", ReadData1, e); end
      tick();
      idle();
      exp_q.push_back(32'hA5A5_A5A5);
      #1;
      e = exp_q.pop_front(); checks++;
      if (ReadData2 !== e) begin failures++; $display("FAIL byp_rd2_after got=%h want=%h", ReadData2, e); end
   endtask

   task automatic test_scoreboard();
      logic [31:0] e;
      logic [31:0] busy_exp [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
      ReadAddr1 = 5'd9; ReadAddr2 = 5'd10;
      issue(5'd9);
      issue(5'd9);
      exp_q.push_back(busy_exp[0]);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL sb_cnt2 got=%b want=%0d", Busy1, e); end
      // Release with cnt=2: not the final write, so still busy while bypassing.
      RegWrite = 1'b1; WriteRegAddr = 5'd9; WriteRegData = 32'h1;
      exp_q.push_back(busy_exp[1]);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL sb_rel_cnt2 got=%b want=%0d", Busy1, e); end
      tick();
      idle();
      exp_q.push_back(busy_exp[2]);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL sb_cnt1 got=%b want=%0d", Busy1, e); end
      RegWrite = 1'b1; WriteRegAddr = 5'd9; WriteRegData = 32'h2;
      IssueValid = 1'b1; IssueAddr = 5'd9;
      tick();
      idle();
      exp_q.push_back(busy_exp[3]);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL sb_same_cycle got=%b want=%0d", Busy1, e); end
      // Final release of 9 together with an issue to 10.
      RegWrite = 1'b1; WriteRegAddr = 5'd9; WriteRegData = 32'h3;
      IssueValid = 1'b1; IssueAddr = 5'd10;
      tick();
      idle();
      exp_q.push_back(busy_exp[4]); exp_q.push_back(busy_exp[5]); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL sb_rel9 got=%b want=%0d", Busy1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy2} !== e) begin failures++; $display("FAIL sb_iss10 got=%b want=%0d", Busy2, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL sb_err got=%b want=%0d", ScoreErr, e); end
   endtask

   task automatic test_errors();
      logic [31:0] e;
      do_reset();
      idle();
      ReadAddr1 = 5'd3;
      for (int i = 0; i < 4; i++) begin
         issue(5'd3);
         exp_q.push_back((i == 3) ? 32'd1 : 32'd0);
         #1;
         e = exp_q.pop_front(); checks++;
         if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL ovf_err i=%0d got=%b want=%0d", i, ScoreErr, e); end
      end
      // A saturated count needs exactly three releases to clear.
      for (int i = 0; i < 3; i++) begin
         RegWrite = 1'b1; WriteRegAddr = 5'd3; WriteRegData = 32'(i);
         tick();
         idle();
         exp_q.push_back((i == 2) ? 32'd0 : 32'd1);
         #1;
         e = exp_q.pop_front(); checks++;
         if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL ovf_sat i=%0d got=%b want=%0d", i, Busy1, e); end
      end
      do_reset();
      idle();
      ReadAddr1 = 5'd4;
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL err_cleared got=%b want=%0d", ScoreErr, e); end
      RegWrite = 1'b1; WriteRegAddr = 5'd4; WriteRegData = 32'h4444_0004;
      tick();
      idle();
      exp_q.push_back(32'd1); exp_q.push_back(32'h4444_0004); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL udf_err got=%b want=%0d", ScoreErr, e); end
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL udf_write got=%h want=%h", ReadData1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy1} !== e) begin failures++; $display("FAIL udf_busy got=%b want=%0d", Busy1, e); end
      // Reset mid-flight drops outstanding counts and data.
      issue(5'd12);
      ReadAddr2 = 5'd12;
      do_reset();
      idle();
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, Busy2} !== e) begin failures++; $display("FAIL rst_flush_busy got=%b want=%0d", Busy2, e); end
      e = exp_q.pop_front(); checks++;
      if (ReadData1 !== e) begin failures++; $display("FAIL rst_flush_data got=%h want=%h", ReadData1, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ScoreErr} !== e) begin failures++; $display("FAIL rst_flush_err got=%b want=%0d", ScoreErr, e); end
   endtask

`ifdef REGFILE_DEBUG_PORT_EN
   task automatic test_debug();
      logic [31:0] e;
      logic [4:0]  addrs [3] = '{5'd1, 5'd0, 5'd2};
      logic [31:0] datas [3] = '{32'h1111_0001, 32'h0000_1234, 32'h2222_0002};
      do_reset();
      idle();
      for (int i = 0; i < 3; i++) begin
         RegWrite = 1'b1; WriteRegAddr = addrs[i]; WriteRegData = datas[i];
         tick();
      end
      idle();
      exp_q.push_back(32'd2);
      #1;
      e = exp_q.pop_front(); checks++;
      if (WriteCount !== e) begin failures++; $display("FAIL dbg_count got=%0d want=%0d", WriteCount, e); end
      for (int i = 0; i < 3; i++) begin
         DbgAddr = addrs[i];
         exp_q.push_back((addrs[i] == 5'd0) ? 32'd0 : datas[i]);
         #1;
         e = exp_q.pop_front(); checks++;
         if (DbgData !== e) begin failures++; $display("FAIL dbg_data a=%0d got=%h want=%h", DbgAddr, DbgData, e); end
      end
      // DbgData must not bypass the in-progress write.
      DbgAddr = 5'd1; RegWrite = 1'b1; WriteRegAddr = 5'd1; WriteRegData = 32'hFFFF_FFFF;
      exp_q.push_back(32'h1111_0001);
      #1;
      e = exp_q.pop_front(); checks++;
      if (DbgData !== e) begin failures++; $display("FAIL dbg_nobypass got=%h want=%h", DbgData, e); end
      idle();
      do_reset();
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (WriteCount !== e) begin failures++; $display("FAIL dbg_count_rst got=%0d want=%0d", WriteCount, e); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b0; ReadAddr1 = '0; ReadAddr2 = '0;
`ifdef REGFILE_DEBUG_PORT_EN
      DbgAddr = '0;
`endif
      idle();
      #2;
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_errors();
`ifdef REGFILE_DEBUG_PORT_EN
      test_debug();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_wb_sink.md
Name: reg_file_wb_sink

Overview:
- General-purpose register file for the 5-stage MIPS core; the write side is the sink of the write-back stage (RegWrite, WriteRegAddr, WriteRegData).
- Two combinational read ports serve the ID stage, with write-through bypass.
- Integrated busy scoreboard: ID marks a destination busy at issue; the write-back port releases it. ID uses the busy flags to stall on read-after-write hazards.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter (max in-flight writes per register = 2^CNT_W-1).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write-back write enable.
- WriteRegAddr  input  5  write-back destination register.
- WriteRegData  input  32  write-back data.
- ReadAddr1  input  5  read port 1 address.
- ReadAddr2  input  5  read port 2 address.
- ReadData1  output  32  read port 1 data.
- ReadData2  output  32  read port 2 data.
- IssueValid  input  1  ID issues an instruction that will write IssueAddr.
- IssueAddr  input  5  destination of the issuing instruction.
- Busy1  output  1  ReadAddr1 has a write still in flight.
- Busy2  output  1  ReadAddr2 has a write still in flight.
- ScoreErr  output  1  sticky scoreboard error flag.

Behaviour:
- Reset (synchronous, active-high) clears all 32 registers, all counters and ScoreErr on the next rising Clk. While Reset is high, writes and issues are ignored.
- Register 0 is hardwired to 0:
  - Writes to address 0 are dropped.
  - Issues to address 0 are dropped.
  - Reads of 0 return 0 and Busy=0.
- Write: at the rising Clk with RegWrite=1 and WriteRegAddr!=0, reg[WriteRegAddr] <= WriteRegData.
- Read: combinational. If RegWrite=1 and WriteRegAddr==ReadAddrN!=0, ReadDataN = WriteRegData (same-cycle bypass). Otherwise ReadDataN = reg[ReadAddrN]. Latency 0.
- Scoreboard: one counter cnt[a] of CNT_W bits per register a, for 1..31.
  - Issue increments cnt[IssueAddr] when IssueValid=1.
  - Release decrements cnt[WriteRegAddr] when RegWrite=1.
  - Issue and release to the same register in the same cycle: cnt is unchanged.
  - Issue and release to different registers in the same cycle: both updates apply.
  - Overflow (issue when cnt is all-ones): cnt saturates, ScoreErr <= 1.
  - Underflow (release when cnt == 0): cnt stays 0, the register write still occurs, ScoreErr <= 1.
- BusyN = (cnt[ReadAddrN] != 0) && !(RegWrite && WriteRegAddr==ReadAddrN && cnt[ReadAddrN]==1). A final write that is being bypassed this cycle does not stall.
- ScoreErr is sticky until Reset.
- Reset asserted mid-operation discards all in-flight counts; the pipeline must be flushed alongside it.

Optional Feature:
- Macro REGFILE_DEBUG_PORT_EN.
- When defined, adds these ports:
  - DbgAddr  input  5
  - DbgData  output  32, combinational reg[DbgAddr] without bypass.
  - WriteCount  output  32, number of committed non-zero-address writes since reset, wrapping at 2^32.
- When undefined, these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then read all addresses → ReadData=0, Busy=0, ScoreErr=0.
- Write reg5=0xDEADBEEF; next cycle read port1 addr5 → 0xDEADBEEF. Write reg0=0x1234 → reads of reg0 stay 0.
- Same-cycle bypass: RegWrite=1, addr 7, data 0xA5A5A5A5, ReadAddr2=7 → ReadData2=0xA5A5A5A5 in that cycle; Busy2=0 when cnt[7] was 1.
- Scoreboard sequence: issue to reg 9 twice → Busy=1 with cnt=2. One release → still Busy. Second release → Busy=0. Simultaneous issue+release to reg 9 → cnt unchanged.
- Error cases with CNT_W=2: four issues to reg 3 → cnt saturates at 3 and ScoreErr=1. After Reset, a release to reg 4 with cnt 0 → ScoreErr=1 and reg4 is written.
- With REGFILE_DEBUG_PORT_EN: perform 3 writes (one to reg0) → WriteCount=2, DbgData matches the written values; Reset → WriteCount=0.
